instr_sequencer: RTL and testbench

- Control sequencer directly downstream of the instruction fetch register. It consumes the 8-bit fetched byte and generates that stage's PC enable, PC load and fetch-register enable.
- Decodes each byte into opcode (upper nibble) and operand (lower nibble). Assembles 12-bit jump targets from two-byte instructions.
- Issues one execute strobe per instruction to the execution datapath, and halts on the HALT opcode.

---
 rtl/instr_sequencer.sv | 110 +++++++++++
 tb/tb_instr_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer behind the fetch register: decodes one- and two-byte instructions,
// drives PC/fetch enables and an execute strobe, and stops on the halt opcode.
module instr_sequencer #(
   parameter int unsigned ADDR_W   = 12,
   parameter logic [3:0]  HALT_OPC = 4'hF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [7:0]        instr,
   input  logic              c_flag,
   input  logic              z_flag,
   output logic              fetch_en,
   output logic              pc_en,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_d,
   output logic [3:0]        opcode,
   output logic [3:0]        oprnd,
   output logic              exec_strobe,
   output logic              halted,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StFetch2 = 3'd2,
      StAddr   = 3'd3,
      StExec   = 3'd4,
      StHalt   = 3'd5
   } state_e;

   state_e     state_q;
   logic [3:0] opcode_q;
   logic [3:0] oprnd_q;
   logic [7:0] addr_lo_q;
   logic       halted_q;
   logic       two_byte;
   logic       taken;
   logic       go;

   // Jump opcodes A..E carry a second address byte.
   assign two_byte = (instr[7:4] >= 4'hA) && (instr[7:4] <= 4'hE);

   always_comb begin
      taken = 1'b0;
      case (opcode_q)
         4'hA:    taken = c_flag;
         4'hB:    taken = ~c_flag;
         4'hC:    taken = z_flag;
         4'hD:    taken = ~z_flag;
         4'hE:    taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StFetch;
         opcode_q  <= 4'h0;
         oprnd_q   <= 4'h0;
         addr_lo_q <= 8'h00;
         halted_q  <= 1'b0;
      end else begin
         case (state_q)
            StFetch:  if (run) state_q <= StDecode;
            StDecode: begin
               if (run) begin
                  opcode_q <= instr[7:4];
                  oprnd_q  <= instr[3:0];
                  state_q  <= two_byte ? StFetch2 : StExec;
               end
            end
            StFetch2: if (run) state_q <= StAddr;
            StAddr: begin
               if (run) begin
                  addr_lo_q <= instr;
                  state_q   <= StExec;
               end
            end
            StExec: begin
               if (run) begin
                  if (opcode_q == HALT_OPC) begin
                     state_q  <= StHalt;
                     halted_q <= 1'b1;
                  end else begin
                     state_q <= StFetch;
                  end
               end
            end
            StHalt:   state_q <= StHalt;
            default:  state_q <= StFetch;
         endcase
      end
   end

   // Strobes are suppressed while stalled and while reset is held.
   assign go          = run & reset;
   assign fetch_en    = go & ((state_q == StFetch) | (state_q == StFetch2));
   assign pc_en       = go & ((state_q == StDecode) | (state_q == StAddr));
   assign exec_strobe = go & (state_q == StExec);
   assign pc_load     = exec_strobe & taken;

   assign pc_d   = {oprnd_q, addr_lo_q};
   assign opcode = opcode_q;
   assign oprnd  = oprnd_q;
   assign halted = halted_q;
   assign state  = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed and randomized instruction streams with random stalls,
// flag noise and mid-instruction resets, checked against a per-instruction expectation model.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic [7:0]  instr;
   logic        c_flag;
   logic        z_flag;
   logic        fetch_en;
   logic        pc_en;
   logic        pc_load;
   logic [11:0] pc_d;
   logic [3:0]  opcode;
   logic [3:0]  oprnd;
   logic        exec_strobe;
   logic        halted;
   logic [2:0]  state;

   instr_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .instr       (instr),
      .c_flag      (c_flag),
      .z_flag      (z_flag),
      .fetch_en    (fetch_en),
      .pc_en       (pc_en),
      .pc_load     (pc_load),
      .pc_d        (pc_d),
      .opcode      (opcode),
      .oprnd       (oprnd),
      .exec_strobe (exec_strobe),
      .halted      (halted),
      .state       (state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Architectural view the model keeps: last decoded opcode/operand and low address byte.
   logic [3:0] m_opc = 4'h0;
   logic [3:0] m_opr = 4'h0;
   logic [7:0] m_lo  = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit jump_taken(input logic [3:0] opc, input logic c, input logic z);
      if (opc == 4'hA) return c;
      if (opc == 4'hB) return !c;
      if (opc == 4'hC) return z;
      if (opc == 4'hD) return !z;
      if (opc == 4'hE) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk_outs(input logic [2:0] st, input logic fe, input logic pe,
                           input logic ex, input logic pl, input logic hl);
      chk("state", state, st);
      chk("fetch_en", fetch_en, fe);
      chk("pc_en", pc_en, pe);
      chk("exec_strobe", exec_strobe, ex);
      chk("pc_load", pc_load, pl);
      chk("halted", halted, hl);
      chk("opcode", opcode, m_opc);
      chk("oprnd", oprnd, m_opr);
      chk("pc_en_vs_pc_load", pc_en & pc_load, 1'b0);
      chk("fetch_en_vs_pc_en", fetch_en & pc_en, 1'b0);
   endtask

   // Asserts reset mid-cycle, checks reset values before the next edge, releases after one edge.
   task automatic do_reset();
      reset  = 1'b0;
      run    = 1'b1;
      instr  = $urandom;
      c_flag = 1'b1;
      z_flag = 1'b0;
      #2;
      m_opc = 4'h0;
      m_opr = 4'h0;
      m_lo  = 8'h00;
      chk_outs(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("pc_d_reset", pc_d, 12'h000);
      tick();
      reset = 1'b1;
   endtask

   // Plays one instruction. cf/zf < 0 means random flag; stall_step inserts stall_n idle
   // cycles before that step; rnd enables random stalls; abort_step resets before that step.
   task automatic do_instr(input logic [7:0] b0, input logic [7:0] b1, input int cf,
                           input int zf, input int stall_step, input int stall_n,
                           input bit rnd, input int abort_step);
      logic [2:0] sts[$];
      int         nst;
      logic       e_pl;
      sts.push_back(3'd0);
      sts.push_back(3'd1);
      if (b0[7:4] >= 4'hA && b0[7:4] <= 4'hE) begin
         sts.push_back(3'd2);
         sts.push_back(3'd3);
      end
      sts.push_back(3'd4);
      foreach (sts[i]) begin
         if (i == abort_step) begin
            do_reset();
            return;
         end
         nst = 0;
         if (i == stall_step) nst = stall_n;
         else if (rnd && $urandom_range(0, 7) == 0) nst = $urandom_range(1, 3);
         repeat (nst) begin
            run    = 1'b0;
            instr  = $urandom;
            c_flag = $urandom;
            z_flag = $urandom;
            #2;
            chk_outs(sts[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
         end
         run    = 1'b1;
         c_flag = (cf < 0) ? 1'($urandom) : 1'(cf);
         z_flag = (zf < 0) ? 1'($urandom) : 1'(zf);
         if (sts[i] == 3'd1) instr = b0;
         else if (sts[i] == 3'd3) instr = b1;
         else instr = $urandom;
         #2;
         e_pl = (sts[i] == 3'd4) && jump_taken(m_opc, c_flag, z_flag);
         chk_outs(sts[i], (sts[i] == 3'd0) || (sts[i] == 3'd2),
                  (sts[i] == 3'd1) || (sts[i] == 3'd3), sts[i] == 3'd4, e_pl, 1'b0);
         if (e_pl) chk("pc_d_target", pc_d, {m_opr, m_lo});
         tick();
         if (sts[i] == 3'd1) begin
            m_opc = b0[7:4];
            m_opr = b0[3:0];
         end
         if (sts[i] == 3'd3) m_lo = b1;
      end
   endtask

   task automatic do_halt(input logic [7:0] b0);
      do_instr(b0, 8'h00, -1, -1, -1, 0, 1'b0, -1);
      repeat (20) begin
         run    = $urandom;
         instr  = $urandom;
         c_flag = $urandom;
         z_flag = $urandom;
         #2;
         chk_outs(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         tick();
      end
      do_reset();
   endtask

   initial begin
      logic [7:0] b0;
      logic [7:0] b1;
      reset  = 1'b0;
      run    = 1'b0;
      instr  = 8'h00;
      c_flag = 1'b0;
      z_flag = 1'b0;
      tick();
      do_reset();

      do_instr(8'h35, 8'h00, -1, -1, -1, 0, 1'b0, -1);
      do_instr(8'h35, 8'h00, -1, -1, -1, 0, 1'b0, -1);
      do_instr(8'hE1, 8'h23, -1, -1, -1, 0, 1'b0, -1);
      chk("jmp_pc_d", pc_d, 12'h123);
      do_instr(8'hA4, 8'h56, 0, -1, -1, 0, 1'b0, -1);
      do_instr(8'hA4, 8'h56, 1, -1, -1, 0, 1'b0, -1);
      do_instr(8'hD2, 8'h34, -1, 1, -1, 0, 1'b0, -1);
      do_instr(8'h35, 8'h00, -1, -1, 1, 4, 1'b0, -1);
      do_instr(8'hE7, 8'h11, -1, -1, -1, 0, 1'b0, 2);
      do_instr(8'h35, 8'h00, -1, -1, -1, 0, 1'b0, -1);
      do_halt(8'hF0);

      repeat (300) begin
         b0 = {4'($urandom_range(0, 14)), 4'($urandom)};
         b1 = $urandom;
         do_instr(b0, b1, -1, -1, -1, 0, 1'b1,
                  ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1);
      end
      do_halt(8'hF9);
      do_instr(8'hB8, 8'h7C, 0, -1, -1, 0, 1'b1, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
